// File: rtl/sprite_pkg.sv
// Shared definitions for the playfield sprites: FSM states, movement
// direction, screen geometry, colour constants and a small range helper.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        DRAW  = 3'd2,
        SHOWN = 3'd3,
        ERASE = 3'd4
    } sprite_state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } sprite_dir_t;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    localparam logic [2:0] BLACK = 3'b000;

    // True when v lies in the closed interval [lo, lo + len_m1].
    // All operands are 10 bits so the upper bound cannot wrap on a 320-wide field.
    function automatic logic in_span(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] len_m1);
        return (v >= lo) && (v <= (lo + len_m1));
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// Row-major pixel scanner shared by the sprite blocks: column/row counters
// that advance one pixel per enabled cycle and wrap after the last pixel.
module sprite_scan
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = 10,
    parameter int unsigned SPRITE_H = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic       last,
    output logic [9:0] x_off,
    output logic [8:0] y_off
);

    localparam logic [4:0] COL_LAST = 5'(SPRITE_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(SPRITE_H - 1);

    logic [4:0] col_r;
    logic [3:0] row_r;

    // Offsets of the current pixel and the flag marking the final pixel.
    always_comb begin
        last  = (col_r == COL_LAST) && (row_r == ROW_LAST);
        x_off = {5'b00000, col_r};
        y_off = {5'b00000, row_r};
    end

    // Step column first, then row; wrap back to pixel 0 after the last one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_r <= 5'd0;
            row_r <= 4'd0;
        end else if (advance) begin
            if (col_r == COL_LAST) begin
                col_r <= 5'd0;
                if (row_r == ROW_LAST) begin
                    row_r <= 4'd0;
                end else begin
                    row_r <= row_r + 4'd1;
                end
            end else begin
                col_r <= col_r + 5'd1;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/alien_sprite.sv
// Alien invader sprite: steps across the field on each draw request,
// bouncing and dropping at the side walls, plots itself pixel by pixel
// and reports hits from the player's bullet.
module alien_sprite
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = 10,
    parameter int unsigned SPRITE_H = 4,
    parameter int unsigned START_X  = 160,
    parameter int unsigned START_Y  = 0,
    parameter int unsigned FIELD_W  = SCREEN_W,
    parameter int unsigned FIELD_H  = SCREEN_H,
    parameter int unsigned STEP     = 1,
    parameter int unsigned DROP     = 1,
    parameter logic [2:0]  COLOUR   = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_signal,
    input  logic       erase_signal,
    input  logic [8:0] bullet_x,
    input  logic [7:0] bullet_y,
    input  logic       bullet_valid,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       finish,
    output logic       collision,
    output logic       busy,
    output logic       landed
);

    localparam logic [9:0] X_MAX    = 10'(FIELD_W - SPRITE_W);
    localparam logic [8:0] Y_MAX    = 9'(FIELD_H - SPRITE_H);
    localparam logic [9:0] STEP_X   = 10'(STEP);
    localparam logic [8:0] DROP_Y   = 9'(DROP);
    localparam logic [9:0] START_X0 = 10'(START_X);
    localparam logic [8:0] START_Y0 = 9'(START_Y);
    localparam logic [9:0] W_M1     = 10'(SPRITE_W - 1);
    localparam logic [9:0] H_M1     = 10'(SPRITE_H - 1);
    localparam logic       LANDED0  = (START_Y == (FIELD_H - SPRITE_H));

    sprite_state_t state_r;
    sprite_dir_t   dir_r;
    sprite_dir_t   move_dir_s;
    logic [9:0]    pos_x_r;
    logic [8:0]    pos_y_r;
    logic          hit_r;
    logic          last_pending_r;

    logic [9:0]    move_x_s;
    logic [8:0]    move_y_s;
    logic [9:0]    x_sum_s;
    logic [8:0]    y_sum_s;
    logic          at_edge_s;
    logic          emit_s;
    logic          hit_now_s;
    logic [9:0]    base_x_s;
    logic [8:0]    base_y_s;
    logic [8:0]    pix_x_s;
    logic [7:0]    pix_y_s;
    logic          scan_last_s;
    logic [9:0]    x_off_s;
    logic [8:0]    y_off_s;

    sprite_scan #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .advance (emit_s),
        .last    (scan_last_s),
        .x_off   (x_off_s),
        .y_off   (y_off_s)
    );

    // Next position/direction taken when the MOVE state commits.
    always_comb begin
        x_sum_s    = pos_x_r + STEP_X;
        y_sum_s    = pos_y_r + DROP_Y;
        at_edge_s  = ((dir_r == DIR_LEFT) && (pos_x_r == 10'd0)) ||
                     ((dir_r == DIR_RIGHT) && (pos_x_r == X_MAX));
        move_x_s   = pos_x_r;
        move_y_s   = pos_y_r;
        move_dir_s = dir_r;
        if (hit_r) begin
            move_x_s   = START_X0;
            move_y_s   = START_Y0;
            move_dir_s = DIR_LEFT;
        end else if (at_edge_s) begin
            move_y_s   = (y_sum_s > Y_MAX) ? Y_MAX : y_sum_s;
            move_dir_s = (dir_r == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
        end else if (dir_r == DIR_LEFT) begin
            move_x_s = (pos_x_r >= STEP_X) ? (pos_x_r - STEP_X) : 10'd0;
        end else begin
            move_x_s = (x_sum_s > X_MAX) ? X_MAX : x_sum_s;
        end
    end

    // A pixel is launched on the MOVE edge, on each scanning edge, and on the erase-accept edge.
    always_comb begin
        emit_s = 1'b0;
        case (state_r)
            MOVE:    emit_s = 1'b1;
            DRAW:    emit_s = !last_pending_r;
            SHOWN:   emit_s = erase_signal;
            ERASE:   emit_s = !last_pending_r;
            default: emit_s = 1'b0;
        endcase
    end

    // Pixel coordinate: the MOVE edge already uses the freshly computed position.
    always_comb begin
        if (state_r == MOVE) begin
            base_x_s = move_x_s;
            base_y_s = move_y_s;
        end else begin
            base_x_s = pos_x_r;
            base_y_s = pos_y_r;
        end
        pix_x_s = 9'(base_x_s + x_off_s);
        pix_y_s = 8'(base_y_s + y_off_s);
    end

    // Bullet overlap, only while the sprite is on screen and not already hit.
    always_comb begin
        if ((state_r == DRAW) || (state_r == SHOWN) || (state_r == ERASE)) begin
            hit_now_s = bullet_valid && !hit_r &&
                        in_span({1'b0, bullet_x}, pos_x_r, W_M1) &&
                        in_span({2'b00, bullet_y}, {1'b0, pos_y_r}, H_M1);
        end else begin
            hit_now_s = 1'b0;
        end
    end

    // Sprite controller: state, position, hit latch and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= IDLE;
            pos_x_r        <= START_X0;
            pos_y_r        <= START_Y0;
            dir_r          <= DIR_LEFT;
            hit_r          <= 1'b0;
            last_pending_r <= 1'b0;
            x              <= 9'd0;
            y              <= 8'd0;
            colour         <= BLACK;
            plot           <= 1'b0;
            finish         <= 1'b0;
            collision      <= 1'b0;
            busy           <= 1'b0;
            landed         <= LANDED0;
        end else begin
            plot      <= 1'b0;
            finish    <= 1'b0;
            collision <= hit_now_s;
            if (hit_now_s) begin
                hit_r <= 1'b1;
            end
            if (emit_s) begin
                x    <= pix_x_s;
                y    <= pix_y_s;
                plot <= 1'b1;
                if (scan_last_s) begin
                    last_pending_r <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    busy <= draw_signal;
                    if (draw_signal) begin
                        state_r <= MOVE;
                    end
                end
                MOVE: begin
                    pos_x_r <= move_x_s;
                    pos_y_r <= move_y_s;
                    dir_r   <= move_dir_s;
                    hit_r   <= 1'b0;
                    landed  <= (move_y_s == Y_MAX);
                    colour  <= COLOUR;
                    busy    <= 1'b1;
                    state_r <= DRAW;
                end
                DRAW: begin
                    if (last_pending_r) begin
                        last_pending_r <= 1'b0;
                        finish         <= 1'b1;
                        busy           <= 1'b0;
                        state_r        <= SHOWN;
                    end
                end
                SHOWN: begin
                    busy <= erase_signal;
                    if (erase_signal) begin
                        colour  <= BLACK;
                        state_r <= ERASE;
                    end
                end
                ERASE: begin
                    if (last_pending_r) begin
                        last_pending_r <= 1'b0;
                        finish         <= 1'b1;
                        busy           <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_sprite.sv
// Directed bench for alien_sprite: two instances (default spawn, and a
// narrow field spawning at x=0), pixel scoreboard, collision and reset abort.
module tb_alien_sprite;

    logic       clk = 1'b0;
    logic       reset;
    logic       draw_sig;
    logic       erase_sig;
    logic       sel;
    logic [8:0] bullet_x;
    logic [7:0] bullet_y;
    logic       bullet_valid;

    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] c0, c1;
    logic       plot0, plot1, fin0, fin1, coll0, coll1, busy0, busy1, land0, land1;

    logic [8:0] ox;
    logic [7:0] oy;
    logic [2:0] ocol;
    logic       oplot, ofin, ocoll, obusy, oland;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    assign ox    = sel ? x1 : x0;
    assign oy    = sel ? y1 : y0;
    assign ocol  = sel ? c1 : c0;
    assign oplot = sel ? plot1 : plot0;
    assign ofin  = sel ? fin1 : fin0;
    assign ocoll = sel ? coll1 : coll0;
    assign obusy = sel ? busy1 : busy0;
    assign oland = sel ? land1 : land0;

    alien_sprite dut0 (
        .clk          (clk),
        .reset        (reset),
        .draw_signal  (draw_sig & !sel),
        .erase_signal (erase_sig & !sel),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_valid (bullet_valid),
        .x            (x0),
        .y            (y0),
        .colour       (c0),
        .plot         (plot0),
        .finish       (fin0),
        .collision    (coll0),
        .busy         (busy0),
        .landed       (land0)
    );

    alien_sprite #(
        .START_X (0),
        .FIELD_W (12),
        .FIELD_H (6)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .draw_signal  (draw_sig & sel),
        .erase_signal (erase_sig & sel),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_valid (bullet_valid),
        .x            (x1),
        .y            (y1),
        .colour       (c1),
        .plot         (plot1),
        .finish       (fin1),
        .collision    (coll1),
        .busy         (busy1),
        .landed       (land1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a draw or erase, scoreboard the 40 pixels, check latency and finish.
    task automatic do_op(input string tag, input bit is_draw, input int bx, input int by,
                         input logic [2:0] col, input int first_lat, input bit poke_erase);
        int cyc;
        int got;
        bit done;
        logic [19:0] e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 10; c++) begin
                exp_q.push_back({9'(bx + c), 8'(by + r), col});
            end
        end
        if (is_draw) draw_sig = 1'b1;
        else erase_sig = 1'b1;
        got  = 0;
        done = 1'b0;
        cyc  = 1;
        while ((cyc <= 60) && !done) begin
            tick();
            draw_sig  = 1'b0;
            erase_sig = 1'b0;
            if (poke_erase && (cyc == 5)) erase_sig = 1'b1;
            if (cyc == 1) check({tag, " busy"}, obusy, 1);
            if (oplot) begin
                if (got == 0) check({tag, " first cycle"}, cyc, first_lat);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, " pixel"}, {ox, oy, ocol}, e);
                end else begin
                    check({tag, " extra pixel"}, got + 1, 40);
                end
                got++;
            end
            if (ofin) begin
                check({tag, " finish cycle"}, cyc, first_lat + 40);
                check({tag, " pixel count"}, got, 40);
                done = 1'b1;
            end
            cyc++;
        end
        if (!done) check({tag, " timeout"}, cyc, 0);
        tick();
        check({tag, " finish pulse"}, ofin, 0);
        check({tag, " idle busy"}, obusy, 0);
        exp_q.delete();
    endtask

    // Present a bullet for two cycles and check the collision pulse.
    task automatic shoot(input string tag, input int bx, input int by, input bit valid,
                         input bit expect_hit);
        bullet_x     = 9'(bx);
        bullet_y     = 8'(by);
        bullet_valid = valid;
        tick();
        check({tag, " collision"}, ocoll, expect_hit);
        tick();
        check({tag, " collision next"}, ocoll, 0);
        bullet_valid = 1'b0;
        tick();
    endtask

    int t_x[8] = '{0, 1, 2, 2, 1, 0, 0, 1};
    int t_y[8] = '{1, 1, 1, 2, 2, 2, 2, 2};
    int t_l[8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        int got;
        bit seen_fin;
        reset        = 1'b0;
        draw_sig     = 1'b0;
        erase_sig    = 1'b0;
        sel          = 1'b0;
        bullet_x     = 9'd0;
        bullet_y     = 8'd0;
        bullet_valid = 1'b0;
        tick();
        tick();
        check("reset x", x0, 0);
        check("reset y", y0, 0);
        check("reset colour", c0, 0);
        check("reset plot", plot0, 0);
        check("reset finish", fin0, 0);
        check("reset collision", coll0, 0);
        check("reset busy", busy0, 0);
        check("reset landed", land0, 0);
        check("reset landed1", land1, 0);
        reset = 1'b1;
        tick();

        // Draw from spawn; an erase during the draw must be dropped.
        do_op("draw1", 1'b1, 159, 0, 3'b101, 2, 1'b1);
        shoot("miss right", 169, 0, 1'b1, 1'b0);
        shoot("miss left", 158, 0, 1'b1, 1'b0);
        shoot("miss below", 160, 4, 1'b1, 1'b0);
        shoot("invalid", 163, 2, 1'b0, 1'b0);
        shoot("hit", 163, 2, 1'b1, 1'b1);
        do_op("erase1", 1'b0, 159, 0, 3'b000, 1, 1'b0);
        do_op("draw respawn", 1'b1, 160, 0, 3'b101, 2, 1'b0);
        do_op("erase2", 1'b0, 160, 0, 3'b000, 1, 1'b0);
        do_op("draw step", 1'b1, 159, 0, 3'b101, 2, 1'b0);
        do_op("erase3", 1'b0, 159, 0, 3'b000, 1, 1'b0);

        // Reset in the middle of a draw aborts it without a finish pulse.
        draw_sig = 1'b1;
        got      = 0;
        for (int i = 0; (i < 60) && (got < 20); i++) begin
            tick();
            draw_sig = 1'b0;
            if (plot0) got++;
        end
        check("abort reached pixel 20", got, 20);
        reset = 1'b0;
        tick();
        check("abort plot", plot0, 0);
        check("abort busy", busy0, 0);
        reset    = 1'b1;
        seen_fin = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fin0 || plot0) seen_fin = 1'b1;
        end
        check("abort no finish", seen_fin, 0);
        do_op("draw after abort", 1'b1, 159, 0, 3'b101, 2, 1'b0);
        check("landed dut0", oland, 0);

        // Narrow field spawning at x=0: bounce, drop, saturate and land.
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("edge draw %0d", i), 1'b1, t_x[i], t_y[i], 3'b101, 2, 1'b0);
            check($sformatf("edge landed %0d", i), oland, t_l[i]);
            do_op($sformatf("edge erase %0d", i), 1'b0, t_x[i], t_y[i], 3'b000, 1, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alien_sprite.md
ALIEN_SPRITE -- requirements
Module: alien_sprite

Interface
REQ-001 SHALL have parameter SPRITE_W, 10, sprite width in pixels (1..32).
REQ-002 SHALL have parameter SPRITE_H, 4, sprite height in pixels (1..16).
REQ-003 SHALL have parameters START_X, 160 and START_Y, 0, spawn position of the top-left pixel.
REQ-004 SHALL have parameters FIELD_W, 320 and FIELD_H, 240, playfield size in pixels.
REQ-005 SHALL have parameters STEP, 1 (horizontal pixels per move), DROP, 1 (rows per edge bounce) and COLOUR, 3'b101 (draw colour).
REQ-006 SHALL have port clk  in  1  system clock, the only clock.
REQ-007 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-008 SHALL have ports draw_signal and erase_signal  in  1 each  single-cycle request pulses.
REQ-009 SHALL have ports bullet_x  in  9, bullet_y  in  8 and bullet_valid  in  1  player bullet position.
REQ-010 SHALL have ports x  out  9, y  out  8, colour  out  3 and plot  out  1  VGA pixel write.
REQ-011 SHALL have ports finish  out  1 (operation-done pulse), collision  out  1 (hit pulse), busy  out  1 and landed  out  1 (level).

Function
REQ-012 SHALL use FSM states IDLE, MOVE, DRAW, SHOWN and ERASE, all advancing on clk only; no logic clocked by draw_signal.
REQ-013 IDLE + draw_signal -> MOVE; MOVE -> DRAW after 1 cycle; DRAW -> SHOWN after the last pixel; SHOWN + erase_signal -> ERASE; ERASE -> IDLE after the last pixel.
REQ-014 draw_signal outside IDLE and erase_signal outside SHOWN SHALL be ignored, with no queuing; if both arrive in IDLE, draw wins.
REQ-015 MOVE, hit latched: position SHALL load (START_X, START_Y), direction left, hit cleared.
REQ-016 MOVE, no hit, at edge (x==0 moving left or x==FIELD_W-SPRITE_W moving right): y += DROP, direction flips, x unchanged.
REQ-017 MOVE otherwise: x moves STEP in direction, clamped to [0, FIELD_W-SPRITE_W]; arithmetic SHALL be 10-bit to avoid wrap.
REQ-018 y SHALL saturate at FIELD_H-SPRITE_H; landed SHALL be high while y equals that value.
REQ-019 DRAW/ERASE SHALL emit SPRITE_W*SPRITE_H pixels, one per cycle, row-major: x=pos_x+col, y=pos_y+row, plot=1.
REQ-020 colour SHALL be COLOUR in DRAW and 3'b000 in ERASE; ERASE SHALL use the position drawn by the preceding DRAW.
REQ-021 Latency: draw_signal in cycle 0 -> first pixel in cycle 2 -> last pixel in cycle 1+W*H -> finish in cycle 2+W*H.
REQ-022 Latency: erase_signal in cycle 0 -> first pixel in cycle 1 -> finish in cycle 1+W*H.
REQ-023 finish SHALL be a 1-cycle pulse; busy SHALL be high in MOVE, DRAW and ERASE.
REQ-024 Hit test in DRAW, SHOWN, ERASE: bullet_valid and pos_x<=bullet_x<=pos_x+W-1 and pos_y<=bullet_y<=pos_y+H-1.
REQ-025 A hit SHALL pulse collision the next cycle and set the hit latch; further hits are suppressed until MOVE clears the latch.
REQ-026 collision and erase_signal in the same cycle SHALL both take effect.

Reset
REQ-027 When reset=0 at a clk edge: state IDLE, position (START_X, START_Y), direction left, hit clear, and plot, finish, collision, busy all 0.
REQ-028 On reset, x=0, y=0, colour=000 and landed=0 (or per start position).
REQ-029 Reset mid-DRAW/ERASE SHALL abort with no finish pulse; pixels already written are not erased.

Structure
REQ-030 Shared package sprite_pkg SHALL hold the state enum, screen dimensions (320x240), colour constants (BLACK=000) and direction encoding.
REQ-031 Sub-module sprite_scan SHALL generate col/row counters, the last-pixel flag and x/y offsets; it is reused by other sprites.

Verification
REQ-032 Reset, then draw_signal: first plot (159,0) in cycle 2, 40 plots ending at (168,3), colour 101, finish in cycle 42.
REQ-033 START_X=0: draw -> drawn at (0,1), direction right; second draw/erase/draw cycle -> drawn at (1,1).
REQ-034 Drawn at (159,0), bullet (163,2) valid -> collision pulse next cycle only; erase then draw -> drawn at (160,0).
REQ-035 Drawn at (159,0), bullets (169,0), (158,0) and (160,4) -> no collision.
REQ-036 erase_signal during DRAW is ignored; in SHOWN -> 40 plots of colour 000, finish, IDLE.
REQ-037 reset=0 at DRAW pixel 20 -> plot=0 next cycle, no finish; a new draw_signal -> normal 40-pixel draw at (159,0).
